// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants for the elastic pipeline stage
// Purpose: state encoding (equal to occupancy) and the default IF/ID payload
//          layout, so fetch packs and decode unpacks the same way.
// Ports:   none (package).
package pipe_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   localparam int IF_ID_INSTR_LSB = 0;
   localparam int IF_ID_PC_LSB    = 32;
   localparam int IF_ID_LINK_LSB  = 96;
   localparam int IF_ID_PAYLOAD_W = 160;

   // Packed view of the default payload; field order matches the LSB offsets.
   typedef struct packed {
      logic [63:0] link_pc;
      logic [63:0] pc;
      logic [31:0] instr;
   } if_id_payload_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
// Purpose: counts cycles where inc is high, sticks at all-ones, never wraps.
// Ports:   clock  - rising-edge clock
//          reset  - asynchronous active-high reset, clears count
//          inc    - count this cycle
//          count  - current value
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry elastic pipeline stage (main + skid)
// Purpose: valid/ready register slice with synchronous flush and a saturating
//          stall-cycle counter. in_ready is registered, so there is no
//          combinational path from out_ready to in_ready.
// Ports:   clock, reset            - clock, asynchronous active-high reset
//          flush                   - kill all held entries
//          in_valid/in_ready/in_data    - upstream handshake and payload
//          out_valid/out_ready/out_data - downstream handshake and payload
//          occupancy               - held entries, 0..2
//          stall_cnt               - saturating count of out_valid & !out_ready
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int                   PAYLOAD_W   = IF_ID_PAYLOAD_W,
   parameter int                   CNT_W       = 16,
   parameter logic [PAYLOAD_W-1:0] FLUSH_VALUE = {PAYLOAD_W{1'b0}}
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data,
   output logic [1:0]           occupancy,
   output logic [CNT_W-1:0]     stall_cnt
);

   logic [1:0]           state_q,    state_d;
   logic [PAYLOAD_W-1:0] main_q,     main_d;
   logic [PAYLOAD_W-1:0] skid_q,     skid_d;
   logic                 in_ready_q, in_ready_d;

   logic in_fire;
   logic out_fire;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid & out_ready;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         main_q     <= FLUSH_VALUE;
         skid_q     <= FLUSH_VALUE;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Next-state and payload movement; flush overrides every transition.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = FLUSH_VALUE;
         skid_d  = FLUSH_VALUE;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d = ST_ONE;
                  main_d  = in_data;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  state_d = ST_FULL;
                  skid_d  = in_data;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only the drain can happen.
               if (out_fire) begin
                  state_d = ST_ONE;
                  main_d  = skid_q;
                  skid_d  = FLUSH_VALUE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
      // Ready for next cycle is decided from the next state, then registered.
      in_ready_d = (state_d != ST_FULL);
   end

   // Output decode
   always_comb begin
      out_valid = (state_q != ST_EMPTY);
      in_ready  = in_ready_q;
      out_data  = main_q;
      occupancy = state_q;
   end

   sat_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (out_valid & ~out_ready),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - self-checking bench for pipe_skid_stage
module tb_pipe_skid_stage;

   logic         clock = 1'b0;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [159:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [159:0] out_data;
   logic [1:0]   occupancy;
   logic [15:0]  stall_cnt;

   logic         s_flush;
   logic         s_in_valid;
   logic         s_in_ready;
   logic [7:0]   s_in_data;
   logic         s_out_valid;
   logic         s_out_ready;
   logic [7:0]   s_out_data;
   logic [1:0]   s_occupancy;
   logic [2:0]   s_stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a bounded FIFO of capacity 2 plus a saturating counter.
   logic [159:0] m_q[$];
   int           m_stall = 0;

   always #5 clock = ~clock;

   pipe_skid_stage dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt)
   );

   pipe_skid_stage #(.PAYLOAD_W(8), .CNT_W(3)) dut_s (
      .clock     (clock),
      .reset     (reset),
      .flush     (s_flush),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in_data),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_data  (s_out_data),
      .occupancy (s_occupancy),
      .stall_cnt (s_stall_cnt)
   );

   // Apply the model to the inputs currently driven, then advance one edge.
   task automatic tick;
      bit of, inf;
      of  = (m_q.size() > 0) && out_ready;
      inf = in_valid && (m_q.size() < 2);
      if ((m_q.size() > 0) && !out_ready && (m_stall < 65535)) m_stall++;
      if (flush) begin
         m_q.delete();
      end else begin
         if (of) void'(m_q.pop_front());
         if (inf) m_q.push_back(in_data);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      flush = 0; out_ready = 0; in_valid = 1; in_data = 160'h55;
      tick();
      n_checks++;
      if (occupancy !== 2'd1) begin n_fail++; $display("FAIL rst_pre_occ: got %0d expected 1", occupancy); end
      #3 reset = 1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
      n_checks++;
      if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_occ: got %0d expected 0", occupancy); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
      n_checks++;
      if (out_data !== 160'h0) begin n_fail++; $display("FAIL rst_out_data: got %0h expected 0", out_data); end
      n_checks++;
      if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stall: got %0d expected 0", stall_cnt); end
      @(posedge clock);
      #1;
      n_checks++;
      if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_hold_occ: got %0d expected 0", occupancy); end
      reset = 0; in_valid = 0;
      m_q.delete(); m_stall = 0;
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_valid: got %0b expected 0", out_valid); end
   endtask

   task automatic test_stream;
      logic [159:0] vals [3];
      vals[0] = 160'hA0; vals[1] = 160'hA1; vals[2] = 160'hA2;
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_data = vals[i];
         tick();
         n_checks++;
         if (out_data !== vals[i] || out_valid !== 1'b1)
            begin n_fail++; $display("FAIL stream_data[%0d]: got %0h/%0b expected %0h/1", i, out_data, out_valid, vals[i]); end
         n_checks++;
         if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d expected 1", i, occupancy); end
      end
      in_valid = 0;
      tick();
      n_checks++;
      if (occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_drain: got %0d expected 0", occupancy); end
   endtask

   task automatic test_backpressure;
      out_ready = 0;
      in_valid = 1; in_data = 160'hB0;
      tick();
      n_checks++;
      if (occupancy !== 2'd1 || stall_cnt !== 16'(m_stall))
         begin n_fail++; $display("FAIL bp_first: got occ %0d stall %0d expected 1 %0d", occupancy, stall_cnt, m_stall); end
      in_data = 160'hB1;
      tick();
      n_checks++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0)
         begin n_fail++; $display("FAIL bp_full: got occ %0d rdy %0b expected 2 0", occupancy, in_ready); end
      in_valid = 0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (stall_cnt !== 16'(m_stall))
            begin n_fail++; $display("FAIL bp_stall[%0d]: got %0d expected %0d", i, stall_cnt, m_stall); end
         tick();
      end
      n_checks++;
      if (out_data !== 160'hB0) begin n_fail++; $display("FAIL bp_head: got %0h expected b0", out_data); end
      out_ready = 1;
      tick();
      n_checks++;
      if (out_data !== 160'hB1 || in_ready !== 1'b1 || occupancy !== 2'd1)
         begin n_fail++; $display("FAIL bp_drain1: got %0h rdy %0b occ %0d expected b1 1 1", out_data, in_ready, occupancy); end
      tick();
      n_checks++;
      if (occupancy !== 2'd0) begin n_fail++; $display("FAIL bp_drain2: got %0d expected 0", occupancy); end
   endtask

   task automatic test_simultaneous;
      out_ready = 0; in_valid = 1; in_data = 160'hC0;
      tick();
      in_data = 160'hC1; out_ready = 1;
      tick();
      n_checks++;
      if (out_data !== 160'hC1 || occupancy !== 2'd1)
         begin n_fail++; $display("FAIL simul: got %0h occ %0d expected c1 1", out_data, occupancy); end
      in_valid = 0;
      tick();
   endtask

   task automatic test_flush_full;
      out_ready = 0; in_valid = 1; in_data = 160'hD0;
      tick();
      in_data = 160'hD1;
      tick();
      flush = 1; in_data = 160'hD2;
      tick();
      flush = 0; in_valid = 0;
      n_checks++;
      if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 160'h0)
         begin n_fail++; $display("FAIL flush_full: got occ %0d v %0b rdy %0b data %0h expected 0 0 1 0", occupancy, out_valid, in_ready, out_data); end
      n_checks++;
      if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL flush_stall: got %0d expected %0d", stall_cnt, m_stall); end
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak[%0d]: got data %0h valid", i, out_data); end
      end
   endtask

   task automatic test_saturation;
      int exp_cnt;
      s_out_ready = 0; s_in_valid = 1; s_in_data = 8'h3C;
      tick();
      s_in_valid = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         exp_cnt = (i > 7) ? 7 : i;
         n_checks++;
         if (s_stall_cnt !== 3'(exp_cnt))
            begin n_fail++; $display("FAIL sat[%0d]: got %0d expected %0d", i, s_stall_cnt, exp_cnt); end
      end
   endtask

   task automatic test_soak;
      int seq = 256;
      for (int c = 0; c < 500; c++) begin
         in_valid  = ($urandom_range(0, 9) < 6);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 99) < 5);
         in_data   = {$urandom(), $urandom(), 96'(seq)};
         seq++;
         tick();
         n_checks++;
         if (occupancy !== 2'(m_q.size()) || out_valid !== (m_q.size() > 0) || in_ready !== (m_q.size() < 2))
            begin n_fail++; $display("FAIL soak_state[%0d]: got occ %0d v %0b rdy %0b expected occ %0d", c, occupancy, out_valid, in_ready, m_q.size()); end
         if (m_q.size() > 0) begin
            n_checks++;
            if (out_data !== m_q[0])
               begin n_fail++; $display("FAIL soak_order[%0d]: got %0h expected %0h", c, out_data, m_q[0]); end
         end
         n_checks++;
         if (in_ready === 1'b1 && occupancy === 2'd2)
            begin n_fail++; $display("FAIL soak_ready_full[%0d]: got in_ready 1 expected 0", c); end
         n_checks++;
         if (stall_cnt !== 16'(m_stall))
            begin n_fail++; $display("FAIL soak_stall[%0d]: got %0d expected %0d", c, stall_cnt, m_stall); end
      end
      flush = 0; in_valid = 0;
   endtask

   initial begin
      reset = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
      s_flush = 0; s_in_valid = 0; s_in_data = '0; s_out_ready = 1;
      repeat (2) @(posedge clock);
      #1 reset = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_simultaneous();
      test_flush_full();
      test_saturation();
      test_soak();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
